// File: rtl/video_mode_switch.sv
// Video mode-switch controller: debounces an MCU command code, maps it to a mode index
// and sequences blank -> PLL reconfiguration handshake -> settle -> re-enable for each switch.
module video_mode_switch #(
    parameter int                                DATA_WIDTH    = 8,
    parameter int                                NUM_MODES     = 3,
    // Code for mode i sits at slice [i*DATA_WIDTH +: DATA_WIDTH].
    parameter logic [NUM_MODES*DATA_WIDTH-1:0]   MODE_CODES    = {8'h02, 8'h01, 8'h00},
    parameter int                                DEFAULT_MODE  = 0,
    parameter int                                STABLE_CYCLES = 4,
    parameter int                                BLANK_CYCLES  = 16,
    parameter int                                SETTLE_CYCLES = 64,
    parameter int                                ACK_TIMEOUT   = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          reconf_ack,
    output logic [$clog2(NUM_MODES)-1:0]  mode_index,
    output logic                          reconf_req,
    output logic                          video_enable,
    output logic                          busy,
    output logic                          unknown_code,
    output logic                          reconf_timeout
);
    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMR_MAX_A = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
    localparam int TMR_MAX = (ACK_TIMEOUT > TMR_MAX_A) ? ACK_TIMEOUT : TMR_MAX_A;
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int ACK_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_BLANK  = 3'd2;
    localparam logic [2:0] ST_RECONF = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    logic [DATA_WIDTH-1:0] sync1_q, sample_q, cand_q, cand_d;
    logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
    logic                  stable;
    logic [NUM_MODES-1:0]  match_vec;
    logic                  match_any;
    logic [MODE_W-1:0]     match_idx;
    logic [2:0]            state_q, state_d;
    logic [MODE_W-1:0]     mode_q, mode_d, target_q, target_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  unknown_q, unknown_d, timeout_q, timeout_d;

    generate
        for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_match
            assign match_vec[gi] = (cand_q == MODE_CODES[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate

    // Descending scan so the lowest matching index wins on duplicate codes.
    always_comb begin
        match_idx = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_idx = MODE_W'(i);
            end
        end
    end

    assign match_any = |match_vec;
    assign stable    = (stab_cnt_q == STAB_W'(STABLE_CYCLES));

    always_comb begin
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        if (sample_q != cand_q) begin
            cand_d     = sample_q;
            stab_cnt_d = '0;
        end else if (!stable) begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        target_d  = target_q;
        tmr_d     = tmr_q;
        unknown_d = unknown_q;
        timeout_d = timeout_q;
        if (stable) begin
            unknown_d = !match_any;
        end
        case (state_q)
            ST_INIT: begin
                state_d  = ST_RECONF;
                target_d = MODE_W'(DEFAULT_MODE);
                tmr_d    = '0;
            end
            ST_IDLE: begin
                if (stable && match_any && (match_idx != mode_q)) begin
                    state_d  = ST_BLANK;
                    target_d = match_idx;
                    tmr_d    = '0;
                end
            end
            ST_BLANK: begin
                if (tmr_q == TMR_W'(BLANK_LAST)) begin
                    state_d = ST_RECONF;
                    mode_d  = target_q;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RECONF: begin
                if (reconf_ack) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(ACK_LAST)) begin
                    state_d   = ST_SETTLE;
                    timeout_d = 1'b1;
                    tmr_d     = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE_LAST)) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sample_q   <= '0;
            cand_q     <= '0;
            stab_cnt_q <= '0;
            state_q    <= ST_INIT;
            mode_q     <= MODE_W'(DEFAULT_MODE);
            target_q   <= MODE_W'(DEFAULT_MODE);
            tmr_q      <= '0;
            unknown_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            sync1_q    <= data_in;
            sample_q   <= sync1_q;
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            tmr_q      <= tmr_d;
            unknown_q  <= unknown_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mode_index     = mode_q;
    assign reconf_req     = (state_q == ST_RECONF);
    assign video_enable   = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign unknown_code   = unknown_q;
    assign reconf_timeout = timeout_q;
endmodule

// File: tb/tb_video_mode_switch.sv
// Bench for video_mode_switch: directed scenarios with literal timing pins, then
// randomized codes/acks/resets, all checked every cycle against a behavioural model.
module tb_video_mode_switch;
    localparam int STABLE = 4;
    localparam int BLANK  = 16;
    localparam int SETTLE = 64;
    localparam int ACK_TO = 1024;
    localparam int NM     = 3;
    localparam int HMAX   = 65536;

    localparam int P_INIT = 0, P_IDLE = 1, P_BLANK = 2, P_RECONF = 3, P_SETTLE = 4;
    localparam int S_REQ = 0, S_VE = 1, S_BUSY = 2, S_MODE = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       reconf_ack = 1'b0;
    logic [1:0] mode_index;
    logic       reconf_req, video_enable, busy, unknown_code, reconf_timeout;

    video_mode_switch #(
        .DATA_WIDTH(8), .NUM_MODES(NM), .MODE_CODES({8'h02, 8'h01, 8'h00}),
        .DEFAULT_MODE(0), .STABLE_CYCLES(STABLE), .BLANK_CYCLES(BLANK),
        .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .reconf_ack(reconf_ack),
        .mode_index(mode_index), .reconf_req(reconf_req), .video_enable(video_enable),
        .busy(busy), .unknown_code(unknown_code), .reconf_timeout(reconf_timeout)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the decoder at edge n sees the data_in captured at edge n-3;
    // a code counts as stable once STABLE+1 consecutive captures agree and at least
    // STABLE edges have passed since reset.
    logic [7:0] hist [HMAX];
    logic [7:0] codes [NM] = '{8'h00, 8'h01, 8'h02};
    int   cyc = 8;
    int   rst_edge = 0;
    int   m_phase = P_INIT, m_age = 0, m_mode = 0, m_target = 0;
    bit   m_unk = 0, m_tmo = 0, m_valid = 0;
    bit   m_stable;
    int   m_found;
    logic [7:0] m_code;

    always @(posedge clock) begin
        cyc++;
        if (cyc >= HMAX - 1) begin
            $display("FAIL model_history: cycle %0d exceeds %0d", cyc, HMAX);
            $fatal(1);
        end
        if (reset) begin
            hist[cyc] = 8'h00;
            hist[cyc-1] = 8'h00;
            hist[cyc-2] = 8'h00;
            rst_edge = cyc;
            m_phase = P_INIT; m_age = 0; m_mode = 0; m_target = 0;
            m_unk = 0; m_tmo = 0; m_valid = 1;
        end else begin
            hist[cyc] = data_in;
            m_code = hist[cyc-3];
            m_stable = (cyc - 1 - rst_edge >= STABLE);
            for (int k = cyc - 3 - STABLE; k < cyc - 3; k++) begin
                if (hist[k] !== m_code) m_stable = 0;
            end
            m_found = -1;
            for (int i = NM - 1; i >= 0; i--) begin
                if (codes[i] == m_code) m_found = i;
            end
            if (m_stable) m_unk = (m_found < 0);
            case (m_phase)
                P_INIT: begin m_phase = P_RECONF; m_age = 0; end
                P_IDLE: begin
                    if (m_stable && m_found >= 0 && m_found != m_mode) begin
                        m_phase = P_BLANK; m_target = m_found; m_age = 0;
                    end
                end
                P_BLANK: begin
                    m_age++;
                    if (m_age == BLANK) begin m_mode = m_target; m_phase = P_RECONF; m_age = 0; end
                end
                P_RECONF: begin
                    m_age++;
                    if (reconf_ack) begin
                        m_phase = P_SETTLE; m_age = 0;
                    end else if (m_age == ACK_TO) begin
                        m_tmo = 1; m_phase = P_SETTLE; m_age = 0;
                    end
                end
                default: begin
                    m_age++;
                    if (m_age == SETTLE) begin m_phase = P_IDLE; m_age = 0; end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("mode_index", 32'(mode_index), m_mode);
            check("reconf_req", 32'(reconf_req), 32'(m_phase == P_RECONF));
            check("video_enable", 32'(video_enable), 32'(m_phase == P_IDLE));
            check("busy", 32'(busy), 32'(m_phase != P_IDLE));
            check("unknown_code", 32'(unknown_code), 32'(m_unk));
            check("reconf_timeout", 32'(reconf_timeout), 32'(m_tmo));
        end
    end

    // PLL stand-in: answers reconf_req after ack_delay cycles, as a pulse or a level.
    bit ack_en = 1;
    bit ack_level = 0;
    int ack_delay = 5;
    int req_age = 0;
    initial begin
        forever begin
            @(negedge clock);
            reconf_ack = 1'b0;
            if (reconf_req === 1'b1 && ack_en) begin
                if (ack_level ? (req_age >= ack_delay) : (req_age == ack_delay)) reconf_ack = 1'b1;
                req_age++;
            end else begin
                req_age = 0;
            end
        end
    end

    function automatic logic [7:0] sig(input int which);
        case (which)
            S_REQ:   return {7'b0, reconf_req};
            S_VE:    return {7'b0, video_enable};
            S_BUSY:  return {7'b0, busy};
            default: return {6'b0, mode_index};
        endcase
    endfunction

    // Counts negedges until the selected output equals val; an expired bound is a failure.
    task automatic count_until(input int which, input logic [7:0] val, input int limit, output int n);
        n = 0;
        while (sig(which) !== val) begin
            @(negedge clock);
            n++;
            if (n > limit) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_timeout: signal %0d still %0h after %0d cycles, wanted %0h",
                         which, sig(which), limit, val);
                break;
            end
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        summary();
        $fatal(1);
    end

    int n;
    int zero_ve;
    initial begin
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 1);
        check("rst_video_enable", 32'(video_enable), 0);
        check("rst_reconf_req", 32'(reconf_req), 0);

        // Reset release: PLL configured straight away, ack after 5 RECONF cycles.
        reset = 1'b0;
        count_until(S_REQ, 8'd1, 10, n);
        check("req_after_reset", n, 1);
        count_until(S_REQ, 8'd0, 50, n);
        check("req_high_cycles", n, 6);
        count_until(S_VE, 8'd1, 200, n);
        check("settle_cycles", n, 64);
        check("mode_after_init", 32'(mode_index), 0);

        // 00 -> 01: blank at cycle 7 after the capturing edge (cycle 0).
        repeat (3) @(negedge clock);
        ack_delay = 3;
        data_in = 8'h01;
        count_until(S_VE, 8'd0, 20, n);
        check("blank_latency", n, 8);
        count_until(S_MODE, 8'd1, 40, n);
        check("blank_cycles", n, 16);
        count_until(S_REQ, 8'd0, 40, n);
        count_until(S_BUSY, 8'd0, 200, n);
        check("busy_after_ack", n, 64);

        // Toggling 01/02 every 2 cycles never settles, then 02 is held.
        zero_ve = 0;
        for (int t = 0; t < 6; t++) begin
            data_in = (t % 2 == 0) ? 8'h02 : 8'h01;
            repeat (2) begin
                @(negedge clock);
                if (video_enable !== 1'b1) zero_ve++;
            end
        end
        check("no_switch_while_toggling", zero_ve, 0);
        data_in = 8'h02;
        count_until(S_VE, 8'd0, 20, n);
        check("toggle_then_hold_latency", n, 8);
        count_until(S_BUSY, 8'd0, 300, n);
        check("mode_after_toggle", 32'(mode_index), 2);

        // Unknown code: flag only, no switch; a valid code clears it.
        data_in = 8'h7F;
        repeat (10) @(negedge clock);
        check("unknown_set", 32'(unknown_code), 1);
        check("unknown_stays_idle", 32'(busy), 0);
        check("unknown_mode_kept", 32'(mode_index), 2);
        data_in = 8'h00;
        repeat (10) @(negedge clock);
        check("unknown_cleared", 32'(unknown_code), 0);
        count_until(S_BUSY, 8'd0, 300, n);
        check("mode_after_unknown", 32'(mode_index), 0);

        // Ack never arrives.
        ack_en = 0;
        data_in = 8'h01;
        count_until(S_REQ, 8'd1, 100, n);
        count_until(S_REQ, 8'd0, 2000, n);
        check("timeout_req_cycles", n, 1024);
        check("timeout_flag", 32'(reconf_timeout), 1);
        count_until(S_BUSY, 8'd0, 100, n);
        check("timeout_settle_cycles", n, 64);
        check("timeout_mode", 32'(mode_index), 1);
        ack_en = 1;

        // New code arrives mid-RECONF: first switch finishes, second follows at once.
        data_in = 8'h00;
        count_until(S_REQ, 8'd1, 60, n);
        data_in = 8'h02;
        count_until(S_BUSY, 8'd0, 300, n);
        check("first_switch_mode", 32'(mode_index), 0);
        count_until(S_BUSY, 8'd1, 20, n);
        check("second_switch_start", n, 1);
        count_until(S_BUSY, 8'd0, 300, n);
        check("second_switch_mode", 32'(mode_index), 2);

        // Reset in the middle of BLANK.
        data_in = 8'h01;
        count_until(S_VE, 8'd0, 20, n);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_mode", 32'(mode_index), 0);
        check("midreset_ve", 32'(video_enable), 0);
        check("midreset_req", 32'(reconf_req), 0);
        check("midreset_timeout_cleared", 32'(reconf_timeout), 0);
        reset = 1'b0;
        count_until(S_REQ, 8'd1, 10, n);
        check("midreset_fresh_req", n, 1);

        // Randomized codes, hold times, ack styles and occasional resets.
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: data_in = 8'h00;
                3, 4:    data_in = 8'h01;
                5, 6:    data_in = 8'h02;
                7:       data_in = 8'h7F;
                default: data_in = 8'($urandom);
            endcase
            ack_delay = $urandom_range(0, 8);
            ack_level = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 30)) @(negedge clock);
        end
        data_in = 8'h01;
        repeat (300) @(negedge clock);

        summary();
        $finish;
    end
endmodule
